hssaer_tx_feeder: RTL and testbench

Front-end stage that sits directly upstream of the HSSAER parallel-AER transmitter wrapper. It accepts address-events from the HPU TX datapath, filters them against a programmable mask/match pair, and buffers accepted events in a small FIFO. It presents them to the transmitter on the `ae`/`src_rdy`/`dst_rdy` handshake and generates the transmitter's `keep_alive` request after a programmable idle interval. It also keeps saturating sent/dropped event counters for the register bank.

---
 rtl/hssaer_tx_feeder_if.sv | 21 ++
 rtl/hssaer_tx_feeder.sv | 140 ++++++++++++++
 tb/tb_hssaer_tx_feeder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hssaer_tx_feeder_if.sv
// rtl/hssaer_tx_feeder_if.sv - upstream event stream plus transmitter ae/src_rdy/dst_rdy handshake
interface hssaer_tx_feeder_if #(
    parameter int int_dsize = 24
) ();
    logic [int_dsize-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [int_dsize-1:0] ae;
    logic                 src_rdy;
    logic                 dst_rdy;

    modport master (
        output in_data, in_valid, dst_rdy,
        input  in_ready, ae, src_rdy
    );

    modport slave (
        input  in_data, in_valid, dst_rdy,
        output in_ready, ae, src_rdy
    );
endinterface

// File: rtl/hssaer_tx_feeder.sv
// rtl/hssaer_tx_feeder.sv - mask/match filter, event FIFO, output register and keep-alive for the HSSAER TX wrapper
module hssaer_tx_feeder #(
    parameter int int_dsize   = 24,
    parameter int fifo_awidth = 2,
    parameter int ka_width    = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 cfg_en,
    input  logic [int_dsize-1:0] cfg_mask,
    input  logic [int_dsize-1:0] cfg_match,
    input  logic [ka_width-1:0]  cfg_ka_period,
    input  logic                 run,
    output logic                 keep_alive,
    output logic [15:0]          sent_cnt,
    output logic [15:0]          drop_cnt,
    hssaer_tx_feeder_if.slave    bus
);
    localparam int depth = 1 << fifo_awidth;
    localparam logic [fifo_awidth:0] depth_c = (fifo_awidth + 1)'(depth);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    logic [int_dsize-1:0]   mem [depth];
    logic [fifo_awidth-1:0] wr_ptr;
    logic [fifo_awidth-1:0] rd_ptr;
    logic [fifo_awidth:0]   count;
    logic                   nrst_q;
    state_t                 state;
    logic [int_dsize-1:0]   ae_q;
    logic                   src_rdy_q;
    logic [ka_width-1:0]    ka_cnt;

    logic full;
    logic empty;
    logic in_fire;
    logic pass;
    logic wr_en;
    logic drop_en;
    logic xfer;
    logic rd_en;
    logic ka_clr;
    logic ka_hit;

    // nrst_q keeps in_ready low through reset and for the release edge itself
    assign full     = (count == depth_c);
    assign empty    = (count == '0);
    assign bus.in_ready = nrst_q & cfg_en & ~full;
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign pass     = ((bus.in_data & cfg_mask) == cfg_match);
    assign wr_en    = in_fire & pass;
    assign drop_en  = in_fire & ~pass;
    assign xfer     = src_rdy_q & bus.dst_rdy;
    assign rd_en    = ~empty & run & ((state == IDLE) | xfer);
    assign ka_clr   = xfer | src_rdy_q | rd_en | ~run | (cfg_ka_period == '0);
    assign ka_hit   = (ka_cnt == cfg_ka_period - ka_width'(1));

    assign bus.ae      = ae_q;
    assign bus.src_rdy = src_rdy_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            nrst_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            ae_q       <= '0;
            src_rdy_q  <= 1'b0;
            ka_cnt     <= '0;
            keep_alive <= 1'b0;
            sent_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            nrst_q <= 1'b1;

            if (wr_en) begin
                wr_ptr <= wr_ptr + fifo_awidth'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + fifo_awidth'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (fifo_awidth + 1)'(1);
                2'b01:   count <= count - (fifo_awidth + 1)'(1);
                default: count <= count;
            endcase

            // once presented, ae/src_rdy only move on a completed transfer
            case (state)
                IDLE: begin
                    if (rd_en) begin
                        ae_q      <= mem[rd_ptr];
                        src_rdy_q <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (xfer) begin
                        if (rd_en) begin
                            ae_q <= mem[rd_ptr];
                        end else begin
                            src_rdy_q <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (xfer && sent_cnt != 16'hFFFF) begin
                sent_cnt <= sent_cnt + 16'd1;
            end
            if (drop_en && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            // a load edge also clears, so a pulse can never coincide with src_rdy rising
            if (ka_clr) begin
                ka_cnt     <= '0;
                keep_alive <= 1'b0;
            end else if (ka_hit) begin
                ka_cnt     <= '0;
                keep_alive <= 1'b1;
            end else begin
                ka_cnt     <= ka_cnt + ka_width'(1);
                keep_alive <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hssaer_tx_feeder.sv
// tb/tb_hssaer_tx_feeder.sv - bench for hssaer_tx_feeder with an event-queue scoreboard
module tb_hssaer_tx_feeder;
    localparam int W = 24;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cfg_en;
    logic [W-1:0]  cfg_mask;
    logic [W-1:0]  cfg_match;
    logic [15:0]   cfg_ka_period;
    logic          run;
    logic          keep_alive;
    logic [15:0]   sent_cnt;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    hssaer_tx_feeder_if #(.int_dsize(W)) bus ();

    hssaer_tx_feeder #(.int_dsize(W), .fifo_awidth(2), .ka_width(16)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .cfg_en        (cfg_en),
        .cfg_mask      (cfg_mask),
        .cfg_match     (cfg_match),
        .cfg_ka_period (cfg_ka_period),
        .run           (run),
        .keep_alive    (keep_alive),
        .sent_cnt      (sent_cnt),
        .drop_cnt      (drop_cnt),
        .bus           (bus)
    );

    int            total = 0;
    int            bad = 0;
    int            ci = 0;
    int            last_xfer_ci = 0;
    int            ka_start;
    int            n_acc;
    logic          ka_prev = 1'b0;
    logic [W-1:0]  exp_q[$];
    int            ka_pulses[$];
    int unsigned   exp_sent = 0;
    int unsigned   exp_drop = 0;
    logic [W-1:0]  vals[6];
    logic [W-1:0]  filt[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_sent"}, {16'h0, sent_cnt}, exp_sent);
        chk({tag, "_drop"}, {16'h0, drop_cnt}, exp_drop);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // One clock: observe accept/transfer just before the edge, update the reference, check after it
    task automatic cycle();
        logic         acc;
        logic         xf;
        logic         hold;
        logic [W-1:0] hold_ae;
        #1;
        acc     = bus.in_valid && bus.in_ready;
        xf      = nrst && bus.src_rdy && bus.dst_rdy;
        hold    = nrst && bus.src_rdy && !bus.dst_rdy;
        hold_ae = bus.ae;
        if (acc) begin
            if ((bus.in_data & cfg_mask) == cfg_match) exp_q.push_back(bus.in_data);
            else if (exp_drop < 65535) exp_drop++;
        end
        if (xf) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL xfer_unexpected observed=%0h expected=none", bus.ae);
            end else begin
                chk("ae_order", bus.ae, exp_q.pop_front());
            end
            if (exp_sent < 65535) exp_sent++;
        end
        @(posedge clk);
        #1;
        ci++;
        if (xf) last_xfer_ci = ci;
        if (!nrst) begin
            exp_q.delete();
            exp_sent = 0;
            exp_drop = 0;
        end
        if (hold) begin
            chk("hold_src_rdy", bus.src_rdy, 1);
            chk("hold_ae", bus.ae, hold_ae);
        end
        if (keep_alive) begin
            chk("ka_while_src_rdy", bus.src_rdy, 0);
            chk("ka_width", ka_prev, 0);
            ka_pulses.push_back(ci);
        end
        ka_prev = keep_alive;
    endtask

    initial begin
        nrst = 1'b0;
        cfg_en = 1'b1;
        cfg_mask = '0;
        cfg_match = '0;
        cfg_ka_period = '0;
        run = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.dst_rdy = 1'b0;

        // reset values
        repeat (3) begin
            cycle();
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_src_rdy", bus.src_rdy, 0);
            chk("rst_ae", bus.ae, 0);
            chk("rst_keep_alive", keep_alive, 0);
            chk("rst_sent", sent_cnt, 0);
            chk("rst_drop", drop_cnt, 0);
        end
        nrst = 1'b1;
        cycle();
        chk("in_ready_after_release", bus.in_ready, 1);

        // back-to-back stream
        run = 1'b1;
        bus.dst_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_data = W'(i);
            bus.in_valid = 1'b1;
            cycle();
            if (i == 1) chk("lat_src_rdy_not_yet", bus.src_rdy, 0);
            if (i == 2) begin
                chk("lat_src_rdy", bus.src_rdy, 1);
                chk("lat_ae", bus.ae, 1);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        chk("stream_sent_const", sent_cnt, 8);
        chk("stream_drop_const", drop_cnt, 0);
        chk_counts("stream");

        // backpressure: 4 in FIFO + 1 in the output register
        bus.dst_rdy = 1'b0;
        for (int k = 0; k < 6; k++) vals[k] = W'($urandom);
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            bus.in_data = vals[n_acc];
            bus.in_valid = 1'b1;
            if (bus.in_ready) n_acc++;
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", n_acc, 5);
        chk("bp_in_ready_full", bus.in_ready, 0);
        chk("bp_ae_first", bus.ae, vals[0]);
        repeat (3) cycle();
        chk("bp_ae_stable", bus.ae, vals[0]);
        bus.dst_rdy = 1'b1;
        repeat (7) cycle();
        chk_counts("bp");

        // filter
        cfg_mask = 24'hF00000;
        cfg_match = 24'h100000;
        filt[0] = 24'h100ABC;
        filt[1] = 24'h200ABC;
        filt[2] = 24'h1FFFFF;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = filt[k];
            bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (4) cycle();
        chk("filter_drop_const", drop_cnt, 1);
        chk("filter_sent_const", sent_cnt, 15);
        chk_counts("filter");

        // run gating
        cfg_mask = '0;
        cfg_match = '0;
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vals[k] = W'($urandom);
            bus.in_data = vals[k];
            bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (3) begin
            cycle();
            chk("gate_src_rdy_low", bus.src_rdy, 0);
        end
        run = 1'b1;
        cycle();
        chk("gate_src_rdy_start", bus.src_rdy, 1);
        chk("gate_ae_first", bus.ae, vals[0]);
        repeat (4) cycle();
        chk_counts("gate");

        // reset in the middle of a presented event
        bus.dst_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = W'($urandom);
            bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("midrst_presenting", bus.src_rdy, 1);
        nrst = 1'b0;
        cycle();
        chk("midrst_src_rdy", bus.src_rdy, 0);
        chk("midrst_sent", sent_cnt, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        nrst = 1'b1;
        bus.dst_rdy = 1'b1;
        repeat (5) cycle();
        chk("midrst_no_stale_src_rdy", bus.src_rdy, 0);
        chk_counts("midrst");

        // randomized traffic
        cfg_mask = 24'h800000;
        cfg_match = '0;
        for (int k = 0; k < 1500; k++) begin
            cfg_en = ($urandom % 8) != 0;
            run = ($urandom % 4) != 0;
            bus.dst_rdy = $urandom % 2;
            bus.in_valid = $urandom % 2;
            bus.in_data = W'($urandom);
            cycle();
        end
        cfg_en = 1'b1;
        run = 1'b1;
        bus.dst_rdy = 1'b1;
        bus.in_valid = 1'b0;
        repeat (8) cycle();
        chk_counts("random");

        // keep-alive
        ka_pulses.delete();
        cfg_ka_period = 16'd10;
        ka_start = ci;
        repeat (45) cycle();
        chk("ka_count", ka_pulses.size(), 4);
        if (ka_pulses.size() > 0) chk("ka_first", ka_pulses[0] - ka_start, 10);
        for (int j = 1; j < ka_pulses.size(); j++) chk("ka_period", ka_pulses[j] - ka_pulses[j-1], 10);
        bus.in_data = W'($urandom);
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        ka_pulses.delete();
        repeat (25) cycle();
        if (ka_pulses.size() == 0) begin
            total++;
            bad++;
            $error("FAIL ka_after_xfer observed=no_pulse expected=pulse");
        end else begin
            chk("ka_after_xfer", ka_pulses[0] - last_xfer_ci, 10);
        end
        cfg_ka_period = 16'd0;
        ka_pulses.delete();
        repeat (25) cycle();
        chk("ka_period_zero", ka_pulses.size(), 0);
        cfg_ka_period = 16'd10;
        run = 1'b0;
        ka_pulses.delete();
        repeat (25) cycle();
        chk("ka_run_low", ka_pulses.size(), 0);
        cfg_ka_period = 16'd0;
        run = 1'b1;
        chk_counts("ka");

        // sent counter saturation
        cfg_mask = '0;
        cfg_match = '0;
        bus.in_valid = 1'b1;
        repeat (65540) begin
            bus.in_data = W'($urandom);
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (4) cycle();
        chk("sat_sent", sent_cnt, 16'hFFFF);
        chk_counts("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
